// File: rtl/clic_csr_stack_timer.sv
// Interrupt-controller support block: one Zicsr CSR with a virtual field
// access path and hardware write port, a free-running timer, and a return stack.
module clic_csr_stack_timer #(
   parameter logic [11:0] CsrAddr        = 12'h300,
   parameter int          CsrWidth       = 8,
   parameter logic [31:0] CsrResetValue  = 32'h0,
   parameter logic [11:0] VcsrAddr       = 12'h400,
   parameter int          StackDepth     = 8,
   parameter int          StackDataWidth = 32,
   parameter int          MonoTimerWidth = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               csr_enable,
   input  logic [11:0]                        csr_addr,
   input  logic [2:0]                         csr_op,
   input  logic [4:0]                         rs1_zimm,
   input  logic [31:0]                        rs1_data,
   input  logic [11:0]                        vcsr_addr,
   input  logic [4:0]                         vcsr_offset,
   input  logic [4:0]                         vcsr_width,
   input  logic [CsrWidth-1:0]                csr_ext_data,
   input  logic                               csr_ext_write_enable,
   output logic [31:0]                        csr_direct_out,
   output logic [31:0]                        csr_out,
   input  logic                               stack_push,
   input  logic                               stack_pop,
   input  logic [StackDataWidth-1:0]          stack_data_in,
   output logic [StackDataWidth-1:0]          stack_data_out,
   output logic [$clog2(StackDepth):0]        stack_index_out,
   output logic [MonoTimerWidth-1:0]          mono_timer
);

   localparam int PtrW = $clog2(StackDepth);
   localparam int IdxW = PtrW + 1;

   logic [CsrWidth-1:0]       r_csr;
   logic [MonoTimerWidth-1:0] r_timer;
   logic [StackDataWidth-1:0] r_stack [StackDepth];
   logic [IdxW-1:0]           r_index;

   logic [31:0] w_csr32;
   logic [31:0] w_operand;
   logic [31:0] w_lowMask;
   logic [31:0] w_fieldMask;
   logic [31:0] w_field;
   logic [31:0] w_fieldOp;
   logic [31:0] w_newField;
   logic [31:0] w_newDirect;
   logic [31:0] w_virtNext;
   logic        w_direct;
   logic        w_virtual;
   logic        w_writeAllowed;
   logic        w_empty;
   logic        w_full;
   logic [PtrW-1:0] w_topPtr;
   logic [PtrW-1:0] w_pushPtr;

   assign w_csr32   = 32'(r_csr);
   assign w_operand = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
   assign w_direct  = csr_enable && (csr_addr == CsrAddr);
   assign w_virtual = csr_enable && (csr_addr == VcsrAddr) && (vcsr_addr == CsrAddr);

   // Field mask of vcsr_width+1 ones; the left shift naturally clips at bit 31.
   assign w_lowMask   = 32'hFFFF_FFFF >> (5'd31 - vcsr_width);
   assign w_fieldMask = w_lowMask << vcsr_offset;
   assign w_field     = (w_csr32 >> vcsr_offset) & w_lowMask;
   assign w_fieldOp   = w_operand & w_lowMask;

   // Set/clear forms with a zero rs1/zimm are read-only; funct3 x00 never writes.
   assign w_writeAllowed = (csr_op[1:0] != 2'b00) && !(csr_op[1] && (rs1_zimm == 5'd0));

   always_comb begin
      w_newDirect = w_csr32;
      w_newField  = w_field;
      case (csr_op[1:0])
         2'b01: begin
            w_newDirect = w_operand;
            w_newField  = w_fieldOp;
         end
         2'b10: begin
            w_newDirect = w_csr32 | w_operand;
            w_newField  = w_field | w_fieldOp;
         end
         2'b11: begin
            w_newDirect = w_csr32 & ~w_operand;
            w_newField  = w_field & ~w_fieldOp;
         end
         default: ;
      endcase
   end

   assign w_virtNext = (w_csr32 & ~w_fieldMask) | ((w_newField << vcsr_offset) & w_fieldMask);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_csr <= CsrResetValue[CsrWidth-1:0];
      end else if (csr_ext_write_enable) begin
         r_csr <= csr_ext_data;
      end else if (w_direct && w_writeAllowed) begin
         r_csr <= w_newDirect[CsrWidth-1:0];
      end else if (w_virtual && w_writeAllowed) begin
         r_csr <= w_virtNext[CsrWidth-1:0];
      end
   end

   assign csr_direct_out = w_csr32;
   assign csr_out = w_direct ? w_csr32 : (w_virtual ? w_field : 32'h0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + MonoTimerWidth'(1);
      end
   end

   assign mono_timer = r_timer;

   assign w_empty   = (r_index == '0);
   assign w_full    = (r_index == IdxW'(StackDepth));
   assign w_topPtr  = PtrW'(r_index - IdxW'(1));
   assign w_pushPtr = r_index[PtrW-1:0];

   // Simultaneous push+pop on a non-empty stack swaps the top entry in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_index <= '0;
      end else if (stack_push && stack_pop && !w_empty) begin
         r_stack[w_topPtr] <= stack_data_in;
      end else if (stack_push && !w_full) begin
         r_stack[w_pushPtr] <= stack_data_in;
         r_index            <= r_index + IdxW'(1);
      end else if (stack_pop && !stack_push && !w_empty) begin
         r_index <= r_index - IdxW'(1);
      end
   end

   assign stack_index_out = r_index;
   assign stack_data_out  = w_empty ? '0 : r_stack[w_topPtr];

endmodule

// File: tb/tb_clic_csr_stack_timer.sv
// Scoreboard bench for clic_csr_stack_timer: a behavioural model queues the
// expected response per cycle and an independent monitor compares the DUT.
module tb_clic_csr_stack_timer;

   localparam logic [11:0] CsrAddr  = 12'h300;
   localparam logic [11:0] VcsrAddr = 12'h400;
   localparam int CsrWidth   = 8;
   localparam int StackDepth = 8;
   localparam int TimerW     = 4;

   typedef struct {
      bit          rst;
      bit          en;
      logic [11:0] addr;
      logic [2:0]  op;
      logic [4:0]  zimm;
      logic [31:0] rs1;
      logic [11:0] vaddr;
      logic [4:0]  voff;
      logic [4:0]  vw;
      logic [7:0]  ext;
      bit          extWe;
      bit          push;
      bit          pop;
      logic [31:0] sdata;
   } stim_t;

   typedef struct {
      string       tag;
      logic [31:0] csrOut;
      logic [31:0] direct;
      int          idx;
      logic [31:0] top;
      int          timer;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        csrEnable = 1'b0;
   logic [11:0] csrAddr = '0;
   logic [2:0]  csrOp = '0;
   logic [4:0]  rs1Zimm = '0;
   logic [31:0] rs1Data = '0;
   logic [11:0] vcsrAddr = '0;
   logic [4:0]  vcsrOffset = '0;
   logic [4:0]  vcsrWidth = '0;
   logic [7:0]  extData = '0;
   logic        extWe = 1'b0;
   logic        stackPush = 1'b0;
   logic        stackPop = 1'b0;
   logic [31:0] stackDataIn = '0;
   logic [31:0] csrDirectOut;
   logic [31:0] csrOut;
   logic [31:0] stackDataOut;
   logic [3:0]  stackIndexOut;
   logic [TimerW-1:0] monoTimer;

   int vectors = 0;
   int miscompares = 0;
   exp_t expQ[$];

   int unsigned mReg = 0;
   int unsigned mTimer = 0;
   logic [31:0] mStack[$];

   clic_csr_stack_timer #(
      .CsrAddr(CsrAddr), .CsrWidth(CsrWidth), .CsrResetValue(32'h0),
      .VcsrAddr(VcsrAddr), .StackDepth(StackDepth), .StackDataWidth(32),
      .MonoTimerWidth(TimerW)
   ) dut (
      .clk(clk), .reset(reset), .csr_enable(csrEnable), .csr_addr(csrAddr),
      .csr_op(csrOp), .rs1_zimm(rs1Zimm), .rs1_data(rs1Data),
      .vcsr_addr(vcsrAddr), .vcsr_offset(vcsrOffset), .vcsr_width(vcsrWidth),
      .csr_ext_data(extData), .csr_ext_write_enable(extWe),
      .csr_direct_out(csrDirectOut), .csr_out(csrOut),
      .stack_push(stackPush), .stack_pop(stackPop), .stack_data_in(stackDataIn),
      .stack_data_out(stackDataOut), .stack_index_out(stackIndexOut),
      .mono_timer(monoTimer)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.vaddr = CsrAddr;
      return s;
   endfunction

   function automatic longint unsigned opResult(longint unsigned old, longint unsigned operand,
                                                logic [2:0] op);
      case (op[1:0])
         2'b01:   return operand;
         2'b10:   return old | operand;
         2'b11:   return old & ~operand;
         default: return old;
      endcase
   endfunction

   // Reference model: computes this cycle's read value, then advances one clock.
   function automatic exp_t modelStep(stim_t s, string tag);
      exp_t e;
      longint unsigned operand, mask, field, nf;
      bit writes, isDirect, isVirt;
      e.tag = tag;
      operand  = s.op[2] ? longint'(s.zimm) : longint'(s.rs1);
      mask     = (64'd1 << (s.vw + 1)) - 1;
      field    = (longint'(mReg) >> s.voff) & mask;
      isDirect = s.en && s.addr == CsrAddr;
      isVirt   = s.en && s.addr == VcsrAddr && s.vaddr == CsrAddr;
      writes   = (s.op == 3'b001 || s.op == 3'b101) ||
                 ((s.op == 3'b010 || s.op == 3'b011 || s.op == 3'b110 || s.op == 3'b111) && s.zimm != 0);
      e.csrOut = isDirect ? mReg : (isVirt ? 32'(field) : 32'h0);
      if (s.rst) begin
         mReg = 0;
         mTimer = 0;
         mStack.delete();
      end else begin
         mTimer = (mTimer + 1) % (1 << TimerW);
         if (s.extWe) begin
            mReg = s.ext;
         end else if (isDirect && writes) begin
            mReg = 32'(opResult(mReg, operand, s.op)) % (1 << CsrWidth);
         end else if (isVirt && writes) begin
            nf = opResult(field, operand & mask, s.op) & mask;
            for (int i = 0; i < 32; i++)
               if (i >= s.voff && i <= s.voff + s.vw) mReg[i] = nf[i - s.voff];
            mReg = mReg % (1 << CsrWidth);
         end
         if (s.push && s.pop && mStack.size() > 0) mStack[mStack.size()-1] = s.sdata;
         else if (s.push && mStack.size() < StackDepth) mStack.push_back(s.sdata);
         else if (s.pop && !s.push && mStack.size() > 0) void'(mStack.pop_back());
      end
      e.direct = mReg;
      e.idx    = mStack.size();
      e.top    = (mStack.size() > 0) ? mStack[mStack.size()-1] : 32'h0;
      e.timer  = int'(mTimer);
      return e;
   endfunction

   task automatic applyStimulus(input stim_t s, input string tag);
      @(negedge clk);
      reset = s.rst; csrEnable = s.en; csrAddr = s.addr; csrOp = s.op;
      rs1Zimm = s.zimm; rs1Data = s.rs1; vcsrAddr = s.vaddr; vcsrOffset = s.voff;
      vcsrWidth = s.vw; extData = s.ext; extWe = s.extWe; stackPush = s.push;
      stackPop = s.pop; stackDataIn = s.sdata;
      expQ.push_back(modelStep(s, tag));
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: read data is sampled mid-low-phase, updated state just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".csr_out"}, csrOut, e.csrOut);
            @(posedge clk);
            #1;
            checkOutput({e.tag, ".direct"}, csrDirectOut, e.direct);
            checkOutput({e.tag, ".index"}, 32'(stackIndexOut), 32'(e.idx));
            checkOutput({e.tag, ".top"}, stackDataOut, e.top);
            checkOutput({e.tag, ".timer"}, 32'(monoTimer), 32'(e.timer));
         end
      end
   end

   initial begin
      stim_t s;
      int opTab[6] = '{1, 2, 3, 5, 6, 7};
      s = idle(); s.rst = 1;
      applyStimulus(s, "reset");
      s = idle();
      repeat (5) applyStimulus(s, "idle");

      s = idle(); s.en = 1; s.addr = CsrAddr; s.op = 3'b001; s.zimm = 5'd1; s.rs1 = 32'hA5;
      applyStimulus(s, "csrrw");
      s.op = 3'b010; s.zimm = 5'd3; s.rs1 = 32'h0A;
      applyStimulus(s, "csrrs");
      s.op = 3'b111; s.zimm = 5'h0F; s.rs1 = 32'hFFFF_FFFF;
      applyStimulus(s, "csrrci");
      s.op = 3'b010; s.zimm = 5'd0; s.rs1 = 32'hFF;
      applyStimulus(s, "csrrs_x0");

      s = idle(); s.en = 1; s.addr = VcsrAddr; s.vaddr = CsrAddr; s.voff = 5'd4; s.vw = 5'd3;
      s.op = 3'b101; s.zimm = 5'd5;
      applyStimulus(s, "vcsr_rwi");
      s = idle(); s.en = 1; s.addr = CsrAddr; s.op = 3'b001; s.zimm = 5'd1; s.rs1 = 32'hFF;
      s.extWe = 1; s.ext = 8'h33;
      applyStimulus(s, "ext_prio");
      s = idle(); s.en = 1; s.addr = VcsrAddr; s.vaddr = CsrAddr; s.voff = 5'd30; s.vw = 5'd7;
      s.op = 3'b001; s.zimm = 5'd1; s.rs1 = 32'hFF;
      applyStimulus(s, "vcsr_clip");

      s = idle(); s.push = 1;
      s.sdata = 32'h100; applyStimulus(s, "push1");
      s.sdata = 32'h200; applyStimulus(s, "push2");
      s.sdata = 32'h300; applyStimulus(s, "push3");
      s.pop = 1; s.sdata = 32'h400; applyStimulus(s, "pushpop");
      s = idle(); s.pop = 1;
      repeat (3) applyStimulus(s, "pop");
      applyStimulus(s, "pop_empty");
      s = idle(); s.push = 1; s.pop = 1; s.sdata = 32'h555;
      applyStimulus(s, "pushpop_empty");
      s = idle(); s.push = 1;
      for (int i = 0; i < StackDepth + 1; i++) begin
         s.sdata = 32'h1000 + i;
         applyStimulus(s, "fill");
      end
      s = idle();
      repeat (16) applyStimulus(s, "wrap");

      for (int n = 0; n < 500; n++) begin
         s = idle();
         s.rst   = ($urandom_range(63) == 0);
         s.en    = ($urandom_range(3) != 0);
         case ($urandom_range(2))
            0: s.addr = CsrAddr;
            1: s.addr = VcsrAddr;
            default: s.addr = 12'($urandom);
         endcase
         s.vaddr = ($urandom_range(3) != 0) ? CsrAddr : 12'($urandom);
         s.op    = 3'(opTab[$urandom_range(5)]);
         s.zimm  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
         s.rs1   = $urandom;
         s.voff  = 5'($urandom);
         s.vw    = 5'($urandom);
         s.extWe = ($urandom_range(7) == 0);
         s.ext   = 8'($urandom);
         s.push  = ($urandom_range(1) == 1);
         s.pop   = ($urandom_range(1) == 1);
         s.sdata = $urandom;
         applyStimulus(s, "rand");
      end

      repeat (3) @(negedge clk);
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
